// File: rtl/if_fetch_stage.sv
// if_fetch_stage: RV32 fetch stage - PC, imem requests, 2-entry fetch queue, redirect/flush handling.
module if_fetch_stage #(
  parameter logic [31:0] BOOT_ADDR = 32'h0000_0000,
  parameter logic [31:0] TRAP_ADDR = 32'h0000_0100,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        ex_valid_in,
  input  logic        branch_taken_in,
  input  logic [31:0] target_in,
  input  logic        jalr_in,
  output logic        imem_req_out,
  output logic [31:0] imem_addr_out,
  input  logic        imem_rvalid_in,
  input  logic [31:0] imem_rdata_in,
  output logic        if_valid_out,
  output logic [31:0] if_instr_out,
  output logic [31:0] if_pc_out,
  output logic [31:0] if_pc_plus4_out,
  input  logic        id_ready_in,
  output logic        misaligned_out
);
  typedef enum logic {RESET, RUN} state_t;
  state_t      state_q, state_d;
  logic        run, redirect, mis, push, pop;
  logic [31:0] tgt;
  logic [1:0]  count_q;
  logic        inflight_q, rd_q, wr_q;
  logic [31:0] inflight_pc_q, pc_q, last_pc_q;
  logic [31:0] q_pc [2];
  logic [31:0] q_ins [2];
  always_ff @(posedge clk_in or negedge rst_n_in)
    if (!rst_n_in) state_q <= RESET;
    else state_q <= state_d;
  always_comb state_d = RUN;
  always_comb run = (state_q == RUN);
  assign redirect        = run & ex_valid_in & branch_taken_in;
  assign tgt             = jalr_in ? {target_in[31:1], 1'b0} : target_in;
  assign mis             = |tgt[1:0];
  assign misaligned_out  = redirect & mis;
  // Backpressure: never more words outstanding than free queue slots.
  assign imem_req_out    = run & ~redirect & ((count_q + {1'b0, inflight_q}) < 2'd2);
  assign imem_addr_out   = pc_q;
  assign push            = ~redirect & imem_rvalid_in & inflight_q;
  assign pop             = ~redirect & if_valid_out & id_ready_in;
  assign if_valid_out    = (count_q != 2'd0);
  assign if_instr_out    = if_valid_out ? q_ins[rd_q] : NOP_INSTR;
  assign if_pc_out       = if_valid_out ? q_pc[rd_q] : last_pc_q;
  assign if_pc_plus4_out = if_pc_out + 32'd4;
  always_ff @(posedge clk_in or negedge rst_n_in)
    if (!rst_n_in) begin
      pc_q          <= BOOT_ADDR;
      count_q       <= 2'd0;
      inflight_q    <= 1'b0;
      inflight_pc_q <= 32'd0;
      rd_q          <= 1'b0;
      wr_q          <= 1'b0;
      last_pc_q     <= 32'd0;
    end else begin
      pc_q       <= redirect ? (mis ? TRAP_ADDR : tgt) : imem_req_out ? pc_q + 32'd4 : pc_q;
      count_q    <= redirect ? 2'd0 : count_q + {1'b0, push} - {1'b0, pop};
      inflight_q <= imem_req_out | (inflight_q & ~imem_rvalid_in & ~redirect);
      rd_q       <= redirect ? 1'b0 : rd_q ^ pop;
      wr_q       <= redirect ? 1'b0 : wr_q ^ push;
      if (imem_req_out) inflight_pc_q <= pc_q;
      if (if_valid_out) last_pc_q <= if_pc_out;
    end
  always_ff @(posedge clk_in)
    if (push) begin
      q_pc[wr_q]  <= inflight_pc_q;
      q_ins[wr_q] <= imem_rdata_in;
    end
endmodule

// File: tb/tb_if_fetch_stage.sv
// tb_if_fetch_stage: directed vector table, async-reset sequence and randomized run against a queue-based model.
module tb_if_fetch_stage;
  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] TRAP = 32'h0000_0100;
  logic        clk_in = 0, rst_n_in = 0;
  logic        ex_valid_in = 0, branch_taken_in = 0, jalr_in = 0;
  logic [31:0] target_in = 0;
  logic        imem_req_out, imem_rvalid_in = 0;
  logic [31:0] imem_addr_out, imem_rdata_in = 0;
  logic        if_valid_out, id_ready_in = 0, misaligned_out;
  logic [31:0] if_instr_out, if_pc_out, if_pc_plus4_out;
  int checks = 0, failures = 0;
  if_fetch_stage dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .ex_valid_in(ex_valid_in),
    .branch_taken_in(branch_taken_in), .target_in(target_in), .jalr_in(jalr_in),
    .imem_req_out(imem_req_out), .imem_addr_out(imem_addr_out),
    .imem_rvalid_in(imem_rvalid_in), .imem_rdata_in(imem_rdata_in),
    .if_valid_out(if_valid_out), .if_instr_out(if_instr_out), .if_pc_out(if_pc_out),
    .if_pc_plus4_out(if_pc_plus4_out), .id_ready_in(id_ready_in), .misaligned_out(misaligned_out)
  );
  always #5 clk_in = ~clk_in;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask
  function automatic logic [31:0] mem(input logic [31:0] a);
    return a == 32'd0 ? 32'h0000_0093 : a == 32'd4 ? 32'h0010_0113 : a ^ 32'h5A5A_0001;
  endfunction
  logic        rsp_v = 0;
  logic [31:0] rsp_a = 0;
  task automatic drive_rsp();
    imem_rvalid_in = rsp_v;
    imem_rdata_in  = rsp_v ? mem(rsp_a) : $urandom;
  endtask
  task automatic latch_rsp();
    rsp_v = imem_req_out;
    rsp_a = imem_addr_out;
  endtask
  typedef struct {
    logic rdy, exv, tk, jr; logic [31:0] tgt;
    logic req; logic [31:0] addr; logic vld; logic [31:0] pc; logic mis;
  } vec_t;
  function automatic vec_t mk(input logic rdy, exv, tk, jr, input logic [31:0] tgt,
                              input logic req, input logic [31:0] addr, input logic vld,
                              input logic [31:0] pc, input logic mis);
    vec_t v;
    v.rdy = rdy; v.exv = exv; v.tk = tk; v.jr = jr; v.tgt = tgt;
    v.req = req; v.addr = addr; v.vld = vld; v.pc = pc; v.mis = mis;
    return v;
  endfunction
  vec_t tbl [26];
  logic        m_run, m_inf;
  logic [31:0] m_pc, m_ipc, m_last;
  logic [31:0] qp [$];
  logic [31:0] qi [$];
  task automatic m_reset();
    m_run = 0; m_inf = 0; m_pc = 0; m_ipc = 0; m_last = 0;
    qp.delete(); qi.delete();
  endtask
  task automatic m_cycle();
    logic redir, mis, e_req, e_vld;
    logic [31:0] t, e_pc, e_ins;
    redir = m_run && ex_valid_in && branch_taken_in;
    t     = jalr_in ? (target_in & ~32'd1) : target_in;
    mis   = redir && (t[1:0] != 2'd0);
    e_req = m_run && !redir && (qp.size() + int'(m_inf) < 2);
    e_vld = qp.size() > 0;
    e_pc  = e_vld ? qp[0] : m_last;
    e_ins = e_vld ? qi[0] : NOP;
    chk("rnd_req", imem_req_out, e_req);
    chk("rnd_addr", imem_addr_out, m_pc);
    chk("rnd_valid", if_valid_out, e_vld);
    chk("rnd_pc", if_pc_out, e_pc);
    chk("rnd_pc4", if_pc_plus4_out, e_pc + 32'd4);
    chk("rnd_instr", if_instr_out, e_ins);
    chk("rnd_mis", misaligned_out, mis);
    if (redir) begin
      qp.delete(); qi.delete();
      m_inf = 0;
      m_pc  = mis ? TRAP : t;
    end else begin
      if (e_vld && id_ready_in) begin
        void'(qp.pop_front());
        void'(qi.pop_front());
      end
      if (imem_rvalid_in && m_inf) begin
        qp.push_back(m_ipc);
        qi.push_back(imem_rdata_in);
        m_inf = 0;
      end
      if (e_req) begin
        m_inf = 1;
        m_ipc = m_pc;
        m_pc  = m_pc + 32'd4;
      end
    end
    if (e_vld) m_last = e_pc;
    m_run = 1;
  endtask
  initial begin
    tbl[0]  = mk(0,0,0,0,0,            0,32'h0,  0,32'h0,0);
    tbl[1]  = mk(0,0,0,0,0,            1,32'h0,  0,32'h0,0);
    tbl[2]  = mk(0,0,0,0,0,            1,32'h4,  0,32'h0,0);
    tbl[3]  = mk(0,0,0,0,0,            0,32'h8,  1,32'h0,0);
    tbl[4]  = mk(0,0,0,0,0,            0,32'h8,  1,32'h0,0);
    tbl[5]  = mk(0,0,0,0,0,            0,32'h8,  1,32'h0,0);
    tbl[6]  = mk(1,0,0,0,0,            0,32'h8,  1,32'h0,0);
    tbl[7]  = mk(1,0,0,0,0,            1,32'h8,  1,32'h4,0);
    tbl[8]  = mk(1,0,0,0,0,            1,32'hC,  0,32'h4,0);
    tbl[9]  = mk(1,1,1,0,32'h40,       0,32'h10, 1,32'h8,0);
    tbl[10] = mk(1,0,0,0,0,            1,32'h40, 0,32'h8,0);
    tbl[11] = mk(1,0,0,0,0,            1,32'h44, 0,32'h8,0);
    tbl[12] = mk(1,1,1,1,32'h85,       0,32'h48, 1,32'h40,0);
    tbl[13] = mk(1,0,0,0,0,            1,32'h84, 0,32'h40,0);
    tbl[14] = mk(1,0,0,0,0,            1,32'h88, 0,32'h40,0);
    tbl[15] = mk(1,1,1,1,32'h86,       0,32'h8C, 1,32'h84,1);
    tbl[16] = mk(1,0,0,0,0,            1,32'h100,0,32'h84,0);
    tbl[17] = mk(1,0,0,0,0,            1,32'h104,0,32'h84,0);
    tbl[18] = mk(1,1,1,0,32'hFFFFFFFC, 0,32'h108,1,32'h100,0);
    tbl[19] = mk(1,0,0,0,0,            1,32'hFFFFFFFC,0,32'h100,0);
    tbl[20] = mk(1,0,0,0,0,            1,32'h0,  0,32'h100,0);
    tbl[21] = mk(1,1,1,0,32'h200,      0,32'h4,  1,32'hFFFFFFFC,0);
    tbl[22] = mk(1,1,1,0,32'h300,      0,32'h200,0,32'hFFFFFFFC,0);
    tbl[23] = mk(1,0,1,0,32'h500,      1,32'h300,0,32'hFFFFFFFC,0);
    tbl[24] = mk(1,0,0,0,0,            1,32'h304,0,32'hFFFFFFFC,0);
    tbl[25] = mk(1,0,0,0,0,            0,32'h308,1,32'h300,0);
    repeat (2) @(negedge clk_in);
    chk("rst_req", imem_req_out, 0);
    chk("rst_addr", imem_addr_out, 0);
    chk("rst_valid", if_valid_out, 0);
    chk("rst_instr", if_instr_out, NOP);
    chk("rst_pc", if_pc_out, 0);
    chk("rst_pc4", if_pc_plus4_out, 4);
    chk("rst_mis", misaligned_out, 0);
    rst_n_in = 1;
    for (int i = 0; i < 26; i++) begin
      id_ready_in = tbl[i].rdy; ex_valid_in = tbl[i].exv; branch_taken_in = tbl[i].tk;
      jalr_in = tbl[i].jr; target_in = tbl[i].tgt;
      drive_rsp();
      #1;
      chk($sformatf("v%0d_req", i), imem_req_out, tbl[i].req);
      chk($sformatf("v%0d_addr", i), imem_addr_out, tbl[i].addr);
      chk($sformatf("v%0d_valid", i), if_valid_out, tbl[i].vld);
      chk($sformatf("v%0d_pc", i), if_pc_out, tbl[i].pc);
      chk($sformatf("v%0d_pc4", i), if_pc_plus4_out, tbl[i].pc + 32'd4);
      chk($sformatf("v%0d_instr", i), if_instr_out, tbl[i].vld ? mem(tbl[i].pc) : NOP);
      chk($sformatf("v%0d_mis", i), misaligned_out, tbl[i].mis);
      latch_rsp();
      @(negedge clk_in);
    end
    id_ready_in = 0; ex_valid_in = 0; branch_taken_in = 0; jalr_in = 0;
    repeat (4) begin
      drive_rsp();
      #1 latch_rsp();
      @(negedge clk_in);
    end
    drive_rsp();
    #2;
    chk("full_before_rst", if_valid_out, 1);
    rst_n_in = 0;
    imem_rvalid_in = 1;
    imem_rdata_in = 32'hDEAD_BEEF;
    #1;
    chk("async_valid", if_valid_out, 0);
    chk("async_instr", if_instr_out, NOP);
    chk("async_req", imem_req_out, 0);
    chk("async_addr", imem_addr_out, 0);
    chk("async_pc", if_pc_out, 0);
    chk("async_pc4", if_pc_plus4_out, 4);
    rsp_v = 0;
    m_reset();
    repeat (2) @(negedge clk_in);
    rst_n_in = 1;
    for (int i = 0; i < 1500; i++) begin
      id_ready_in = ($urandom_range(0, 3) != 0);
      jalr_in = $urandom_range(0, 1);
      if ($urandom_range(0, 7) == 0) begin
        ex_valid_in = 1; branch_taken_in = 1;
      end else begin
        ex_valid_in = $urandom_range(0, 1); branch_taken_in = 0;
      end
      target_in = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'h0000_0FFF);
      drive_rsp();
      if (!rsp_v && (i == 0 || $urandom_range(0, 15) == 0)) imem_rvalid_in = 1;
      #1;
      m_cycle();
      latch_rsp();
      @(negedge clk_in);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
